cim_shift_acc: RTL and testbench
================================

// Module: cim_shift_acc
// PURPOSE
//   Bit-serial shift-and-add accumulator directly downstream of the 16-bit signed CLA adder tree.
//   Each beat takes one signed partial sum, i.e. the CIM column result for one input bit plane.
//   Planes arrive MSB first; the block forms acc = (acc<<1) +/- psum over IN_BITS beats.
//   Emits the full-precision MAC result through a valid/ready handshake to the output buffer.
// PARAMETERS
//   PSUM_W   16           width of signed partial sum from adder stage
//   IN_BITS  8            input activation bit planes per operation (>=2)
//   ACC_W    PSUM_W+IN_BITS  result width; overflow-free by construction
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   start      in   1        begin new operation (sampled in IDLE only)
//   act_signed in   1        sampled with start: 1 = activations two's complement
//   abort      in   1        synchronous cancel; return to IDLE, no output
//   in_valid   in   1        in_psum valid
//   in_psum    in   PSUM_W   signed partial sum, current bit plane
//   in_ready   out  1        block accepts a beat
//   out_valid  out  1        out_data valid
//   out_data   out  ACC_W    signed accumulated result
//   out_ready  in   1        downstream accepts result
//   busy       out  1        high in ACC or DONE
// BEHAVIOUR
//   Reset (async, any state)
//     state=IDLE, acc=0, beat_cnt=0, signed_q=0.
//     in_ready=0, out_valid=0, out_data=0, busy=0.
//   FSM states: IDLE, ACC, DONE.
//     IDLE: start=1 -> ACC; acc<=0, beat_cnt<=0, signed_q<=act_signed.
//     ACC: in_ready=1. A beat is accepted when in_valid&in_ready.
//       First beat (cnt==0): acc <= signed_q ? -sext(psum) : sext(psum).
//       Later beats: acc <= (acc<<1) + sext(psum).
//       cnt increments per beat; on beat IN_BITS-1, go to DONE.
//     DONE: out_valid=1, out_data=acc, held stable until out_ready.
//       out_valid&out_ready -> IDLE. A new start is needed for the next op.
//   Latency: out_valid rises the cycle after the last beat is accepted.
//   in_valid gaps stall accumulation; acc and cnt hold.
//   in_valid while not in ACC is ignored; in_ready=0 there.
//   start outside IDLE is ignored. start&abort in IDLE: abort wins, stay IDLE.
//   abort in ACC or DONE -> IDLE next cycle.
//     acc is cleared; out_valid drops; no handshake is completed.
//     A beat presented in the same cycle as abort is discarded.
//   Arithmetic: sign-extend psum to ACC_W; all math in ACC_W two's complement.
//     Negating psum=-2^(PSUM_W-1) is exact in ACC_W.
//   out_data is 0 whenever out_valid=0.
// TESTING
//   Unsigned, 8 beats psum=1, no gaps -> out_data=255, out_valid 1 cycle after 8th beat.
//   Signed, 8 beats psum=1 -> out_data=-1 (0xFFFFFF).
//   Signed, beat0 psum=-32768, beats1-7 psum=0 -> out_data=0x400000 (+4194304).
//   Unsigned, 8 beats psum=-32768 -> out_data=-8355840.
//     Hold out_ready=0 for 5 cycles -> out_valid and out_data stable throughout.
//   in_valid toggled 1/0 each cycle over 8 beats of psum=3 (unsigned).
//     -> out_data=765; in_ready high only in ACC.
//   Assert abort after beat 4, then start a new op -> no out_valid from the first op.
//     Assert rst mid-ACC -> all outputs 0 immediately.
//     The next op gives a correct result from acc=0.

Source files
------------

// File: rtl/cim_shift_acc.sv
// rtl/cim_shift_acc.sv - bit-serial shift-and-add MAC accumulator fed by the CIM adder tree
// Planes arrive MSB first; the first plane carries negative weight for signed activations.
module cim_shift_acc #(
  parameter int PSUM_W  = 16,
  parameter int IN_BITS = 8,
  parameter int ACC_W   = PSUM_W + IN_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     act_signed,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic signed [PSUM_W-1:0] in_psum,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int CNT_W = $clog2(IN_BITS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_BITS - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                    state, state_d;
  logic signed [ACC_W-1:0]   acc, acc_d;
  logic [CNT_W-1:0]          cnt, cnt_d;
  logic                      signed_q, signed_d;
  logic signed [ACC_W-1:0]   psum_ext;

  assign psum_ext = {{(ACC_W-PSUM_W){in_psum[PSUM_W-1]}}, in_psum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      signed_q <= 1'b0;
    end else begin
      state    <= state_d;
      acc      <= acc_d;
      cnt      <= cnt_d;
      signed_q <= signed_d;
    end
  end

  always_comb begin
    state_d   = state;
    acc_d     = acc;
    cnt_d     = cnt;
    signed_d  = signed_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d  = ACC;
          acc_d    = '0;
          cnt_d    = '0;
          signed_d = act_signed;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // abort discards any beat presented in the same cycle
        if (abort) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (in_valid) begin
          if (cnt == '0)
            acc_d = signed_q ? -psum_ext : psum_ext;
          else
            acc_d = (acc <<< 1) + psum_ext;
          cnt_d = cnt + CNT_W'(1);
          if (cnt == LAST_BEAT)
            state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = acc;
        busy      = 1'b1;
        if (abort || out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cim_shift_acc.sv
// tb/tb_cim_shift_acc.sv - scoreboard bench for cim_shift_acc against an arithmetic MAC model
module tb_cim_shift_acc;

  localparam int PSUM_W  = 16;
  localparam int IN_BITS = 8;
  localparam int ACC_W   = 24;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic                     act_signed = 1'b0;
  logic                     abort = 1'b0;
  logic                     in_valid = 1'b0;
  logic signed [PSUM_W-1:0] in_psum = '0;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_ready = 1'b1;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] exp_q[$];

  cim_shift_acc #(.PSUM_W(PSUM_W), .IN_BITS(IN_BITS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .act_signed(act_signed), .abort(abort),
    .in_valid(in_valid), .in_psum(in_psum), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Each plane i (MSB first) weighs 2^(IN_BITS-1-i); the MSB plane is negative for signed activations.
  function automatic longint ref_mac(input bit s, input int ps[IN_BITS]);
    longint r = 0;
    for (int i = 0; i < IN_BITS; i++) begin
      longint w = longint'(1) << (IN_BITS - 1 - i);
      if (i == 0 && s) r -= longint'(ps[i]) * w;
      else             r += longint'(ps[i]) * w;
    end
    return r;
  endfunction

  function automatic int rnd_psum();
    int k = $urandom_range(0, 9);
    if (k == 0) return -32768;
    if (k == 1) return 32767;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Monitor: pops the scoreboard on each completed handshake and checks hold stability.
  logic             hold_prev = 1'b0;
  logic [ACC_W-1:0] data_prev = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {8'd0, out_data}, {8'd0, data_prev});
      end
      if (!out_valid) begin
        if (out_data !== '0) chk("data_zero_idle", {8'd0, out_data}, 32'd0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {8'd0, out_data}, 32'hDEAD);
        end else begin
          chk("result", {8'd0, out_data}, {8'd0, exp_q.pop_front()});
        end
      end
      hold_prev = out_valid && !out_ready;
      data_prev = out_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap: 0 none, 1 alternate idle cycles, 2 random idle cycles
  task automatic run_op(input bit s, input int ps[IN_BITS], input int gap, input int rdly);
    longint e = ref_mac(s, ps);
    exp_q.push_back(e[ACC_W-1:0]);
    out_ready = (rdly == 0);
    start = 1'b1;
    act_signed = s;
    tick();
    start = 1'b0;
    act_signed = $urandom_range(0, 1);
    chk("in_ready_acc", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < IN_BITS; i++) begin
      int idle = (gap == 1 && i > 0) ? 1 : (gap == 2 ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < idle; g++) begin
        in_valid = 1'b0;
        in_psum = PSUM_W'($urandom);
        tick();
        if (gap == 1) chk("in_ready_gap", {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b1;
      in_psum = PSUM_W'(ps[i]);
      tick();
    end
    in_valid = 1'b0;
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    if (rdly > 0) begin
      repeat (rdly) tick();
      out_ready = 1'b1;
    end
    for (int n = 0; n < 20 && busy; n++) tick();
    if (busy) chk("done_timeout", {31'd0, busy}, 32'd0);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic fill(output int ps[IN_BITS], input int v);
    for (int i = 0; i < IN_BITS; i++) ps[i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ps[IN_BITS];
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {8'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    fill(ps, 1);
    run_op(1'b0, ps, 0, 0);
    run_op(1'b1, ps, 0, 0);
    fill(ps, 0);
    ps[0] = -32768;
    run_op(1'b1, ps, 0, 0);
    fill(ps, -32768);
    run_op(1'b0, ps, 0, 5);
    fill(ps, 3);
    run_op(1'b0, ps, 1, 0);

    // in_valid and start with abort while idle are both ignored
    in_valid = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    chk("start_abort_idle", {31'd0, busy}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;

    // abort after four beats; the beat presented alongside abort is dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_psum = PSUM_W'(rnd_psum());
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < IN_BITS; i++) ps[i] = rnd_psum();
    run_op(1'b1, ps, 0, 0);

    // asynchronous reset mid-accumulation
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_psum = 16'sd1234;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", {8'd0, out_data}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    fill(ps, 7);
    run_op(1'b0, ps, 0, 0);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < IN_BITS; i++) ps[i] = rnd_psum();
      run_op(1'($urandom_range(0, 1)), ps, 2, int'($urandom_range(0, 3)));
    end

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
